stopwatch_lap_hold: RTL and testbench
=====================================

# stopwatch_lap_hold

Lap-capture and display-select stage between the `stopwatch` counter and `SevenSegmentControl` on the stopwatch board. Debounces a raw lap button and a raw recall button and stores up to `LAP_DEPTH` BCD lap times in a circular buffer. It drives the 16-bit display word with one of three values: live time, a frozen lap time, or a recalled older lap.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive stable cycles required to accept a button level change; minimum 1.
- `LAP_DEPTH`, default 4: lap buffer entries; 1 to 4 (one decimal point per entry).

- `clk`  in  1: system clock; all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous clear, already debounced (the stopwatch reset button); empties the buffer.
- `btn_lap`  in  1: raw asynchronous lap button, active-high.
- `btn_recall`  in  1: raw asynchronous recall button, active-high.
- `time_in`  in  16: live BCD time from `stopwatch` (digit3..digit0 = [15:12]..[3:0]).
- `data_out`  out  16: word to the `SevenSegmentControl` `dataIn` input.
- `digit_point`  out  4: active-high; bit i set while lap entry i is shown in RECALL.
- `lap_count`  out  3: number of valid stored laps, 0..`LAP_DEPTH`.
- `frozen`  out  1: high in HOLD or RECALL.

## Operation
- **Button path, per button:**
  - 2-flop synchronizer.
  - Debounce counter: resets whenever the synced level equals the debounced level. When the synced level has differed for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level takes the new value.
  - A rising edge of the debounced level produces a 1-cycle pulse (`lap_p`, `rec_p`).
- **Buffer:**
  - `LAP_DEPTH` x 16 registers, write pointer `wp`, count `lap_count`.
  - A store writes `time_in` at `wp`, then advances `wp` modulo `LAP_DEPTH`.
  - `lap_count` saturates at `LAP_DEPTH`. Once the buffer is full, each store overwrites the oldest entry.
- **FSM (reset state LIVE):**
  - LIVE: `data_out` = `time_in`.
    - `lap_p`: store; `hold_reg` <= `time_in`; go HOLD.
    - `rec_p` with `lap_count`>0: `rd` <= newest index; go RECALL.
    - `rec_p` with `lap_count`=0: ignored.
  - HOLD: `data_out` = `hold_reg`.
    - `lap_p`: go LIVE, no store.
    - `rec_p`: enter RECALL at the newest entry, same as from LIVE.
  - RECALL: `data_out` = `buf[rd]`; `digit_point` = one-hot(`rd`).
    - `rec_p`: step `rd` to the next-older entry (modulo `LAP_DEPTH`). After the oldest valid entry, go LIVE.
    - `lap_p`: go LIVE, no store.
- **Priority:**
  - `clear` beats everything: it zeroes `lap_count`, `wp`, `hold_reg` and buffer, and forces LIVE.
  - When `lap_p` and `rec_p` occur in the same cycle, `lap_p` wins and `rec_p` is dropped.
- **Outputs:** `digit_point` = 0 outside RECALL; `frozen` = (state != LIVE).

## Timing
- Reset (`reset_n` low): `data_out`=0, `digit_point`=0, `lap_count`=0, `frozen`=0, state LIVE, buffer and `hold_reg` zeroed, debounced levels 0, counters 0.
- Button latency: a raw level stable from edge k produces its pulse at edge k+2+`DEBOUNCE_CYCLES`.
- Button glitches shorter than `DEBOUNCE_CYCLES` cycles produce no pulse.
- All outputs are registered: state and `data_out` update one cycle after the pulse.
- In LIVE, `data_out` follows `time_in` with one cycle of latency.
- The stored lap value is `time_in` sampled on the pulse cycle. Holding a button produces exactly one pulse; release produces none.
- `clear` takes effect on the edge where it is sampled high; outputs reflect it the following cycle.
- `reset_n` assertion mid-debounce or mid-recall aborts immediately; no pulse is generated after release.

## Configuration
- `LAP_RECALL_EN` defined: full behaviour as above.
- `LAP_RECALL_EN` undefined:
  - No buffer, no RECALL state; `btn_recall` is ignored; `digit_point` is tied to 0.
  - `lap_count` counts laps, saturating at `LAP_DEPTH`.
  - LIVE/HOLD toggle on `lap_p` is unchanged.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `LAP_DEPTH`=4.
- Reset then idle: `data_out`=0 and `frozen`=0; with `time_in`=16'h1234, `data_out`=16'h1234 one cycle later.
- Glitch and clean press: a 3-cycle `btn_lap` pulse causes no state change. A held press with `time_in`=16'h0105 gives HOLD at edge k+7, `data_out`=16'h0105 thereafter while `time_in` keeps counting, and `lap_count`=1.
- Wrap: 5 lap/lap sequences storing 16'h0001..16'h0005 give `lap_count`=4. Successive recalls show 0005, 0004, 0003, 0002 with `digit_point` 0001, 1000, 0100, 0010; the next recall returns to LIVE.
- Recall with `lap_count`=0: `rec_p` leaves state LIVE and `digit_point`=0.
- Simultaneous presses: lap and recall rise on the same edge in LIVE, giving HOLD and `lap_count`+1, not RECALL.
- `clear` in RECALL gives LIVE, `lap_count`=0, `data_out`=`time_in` next cycle; `reset_n` pulsed mid-debounce gives no pulse after release.

Source files
------------

// File: rtl/stopwatch_lap_hold.sv
// stopwatch_lap_hold: debounced lap capture, lap buffer recall and display word select
// Ports: clk, reset_n (async active-low), clear (sync, empties laps), btn_lap/btn_recall (raw buttons),
//   time_in (live BCD time), data_out (display word), digit_point (one-hot of recalled entry),
//   lap_count (valid laps), frozen (display not live).
// Build option LAP_RECALL_EN: lap buffer plus RECALL mode; without it only LIVE/HOLD and a lap counter.
module stopwatch_lap_hold_btn #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic s1, s2, deb, deb_d;
  logic [CW-1:0] cnt;
  // pulse is registered off the debounced level, so the FSM acts one edge after the rise is seen
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      deb <= 1'b0;
      deb_d <= 1'b0;
      pulse <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      if (s2 == deb) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

module stopwatch_lap_hold #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LAP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        btn_lap,
  input  logic        btn_recall,
  input  logic [15:0] time_in,
  output logic [15:0] data_out,
  output logic [3:0]  digit_point,
  output logic [2:0]  lap_count,
  output logic        frozen
);
  typedef enum logic [1:0] {LIVE, HOLD, RECALL} state_t;
  state_t state, state_nx;
  logic lap_p, store, rec_go, rec_end;
  logic [1:0] rd_nx;
  logic [15:0] hold_reg, rec_val, data_nx;
  logic [3:0] dp_nx;
  stopwatch_lap_hold_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(clk), .reset_n(reset_n), .btn(btn_lap), .pulse(lap_p)
  );
`ifdef LAP_RECALL_EN
  logic rec_p;
  logic [1:0] wp, rd, rn, rn_nx, newest;
  logic [15:0] lap_buf [LAP_DEPTH];
  stopwatch_lap_hold_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rec (
    .clk(clk), .reset_n(reset_n), .btn(btn_recall), .pulse(rec_p)
  );
  assign newest = wp == 2'd0 ? 2'(LAP_DEPTH - 1) : wp - 2'd1;
  // rn counts the older entries still to be shown; recall ends when it runs out
  always_comb begin
    rd_nx = rd;
    rn_nx = rn;
    rec_go = 1'b0;
    rec_end = 1'b0;
    if (rec_p && !lap_p && state != RECALL && lap_count != 3'd0) begin
      rec_go = 1'b1;
      rd_nx = newest;
      rn_nx = 2'(lap_count - 3'd1);
    end else if (rec_p && !lap_p && state == RECALL) begin
      rec_end = rn == 2'd0;
      rd_nx = rd == 2'd0 ? 2'(LAP_DEPTH - 1) : rd - 2'd1;
      rn_nx = rn - 2'd1;
    end
  end
  assign rec_val = lap_buf[rd_nx];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= 2'd0;
      rd <= 2'd0;
      rn <= 2'd0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_buf[i] <= '0;
    end else if (clear) begin
      wp <= 2'd0;
      rd <= 2'd0;
      rn <= 2'd0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_buf[i] <= '0;
    end else begin
      rd <= rd_nx;
      rn <= rn_nx;
      if (store) begin
        lap_buf[wp] <= time_in;
        wp <= wp == 2'(LAP_DEPTH - 1) ? 2'd0 : wp + 2'd1;
      end
    end
`else
  logic unused_recall;
  assign unused_recall = btn_recall;
  assign rec_go = 1'b0;
  assign rec_end = 1'b0;
  assign rd_nx = 2'd0;
  assign rec_val = 16'd0;
`endif
  // a lap pulse always wins over a recall pulse in the same cycle
  always_comb begin
    state_nx = state;
    store = 1'b0;
    if (lap_p) begin
      store = state == LIVE;
      state_nx = state == LIVE ? HOLD : LIVE;
    end else if (rec_go) state_nx = RECALL;
    else if (rec_end) state_nx = LIVE;
    data_nx = state_nx == LIVE ? time_in : state_nx == HOLD ? (store ? time_in : hold_reg) : rec_val;
    dp_nx = state_nx == RECALL ? 4'd1 << rd_nx : 4'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= LIVE;
      hold_reg <= '0;
      lap_count <= '0;
      data_out <= '0;
      digit_point <= '0;
      frozen <= 1'b0;
    end else if (clear) begin
      state <= LIVE;
      hold_reg <= '0;
      lap_count <= '0;
      data_out <= time_in;
      digit_point <= '0;
      frozen <= 1'b0;
    end else begin
      state <= state_nx;
      data_out <= data_nx;
      digit_point <= dp_nx;
      frozen <= state_nx != LIVE;
      if (store) begin
        hold_reg <= time_in;
        if (lap_count != 3'(LAP_DEPTH)) lap_count <= lap_count + 3'd1;
      end
    end
endmodule

// File: tb/tb_stopwatch_lap_hold.sv
// tb_stopwatch_lap_hold: directed and randomized checks of stopwatch_lap_hold against a lap-list model
module tb_stopwatch_lap_hold;
  localparam int D = 4;
  localparam int N = 4;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, btn_lap = 1'b0, btn_recall = 1'b0;
  logic [15:0] time_in = 16'd0;
  logic [15:0] data_out;
  logic [3:0] digit_point;
  logic [2:0] lap_count;
  logic frozen;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  stopwatch_lap_hold #(.DEBOUNCE_CYCLES(D), .LAP_DEPTH(N)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .btn_lap(btn_lap), .btn_recall(btn_recall),
    .time_in(time_in), .data_out(data_out), .digit_point(digit_point), .lap_count(lap_count), .frozen(frozen)
  );
  // model: raw sample history per button, laps as a list with newest at the back,
  // mode 0 live / 1 hold / 2 recall, pos = how many laps back from the newest is shown
  bit hl[$], hr[$];
  bit deb_l, deb_r, rl1, rl2, rr1, rr2;
  int mode, pos, sc;
  logic [15:0] laps[$];
  logic [15:0] hold_v, exp_data;
  logic [3:0] exp_dp;
  function automatic bit settled(input bit q[$], input bit lvl);
    for (int i = 1; i <= D; i++) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_clear(input logic [15:0] d);
    mode = 0; pos = 0; sc = 0; laps.delete(); hold_v = 16'd0; exp_data = d; exp_dp = 4'd0;
  endtask
  task automatic model_reset();
    hl.delete(); hr.delete();
    for (int i = 0; i < D + 2; i++) begin hl.push_back(1'b0); hr.push_back(1'b0); end
    deb_l = 0; deb_r = 0; rl1 = 0; rl2 = 0; rr1 = 0; rr2 = 0;
    model_clear(16'd0);
  endtask
  task automatic model_edge();
    bit al, ar, nl, nr;
    if (!reset_n) begin model_reset(); return; end
    al = rl2; ar = rr2;
    hl.push_back(btn_lap); hr.push_back(btn_recall);
    nl = settled(hl, deb_l); nr = settled(hr, deb_r);
    void'(hl.pop_front()); void'(hr.pop_front());
    rl2 = rl1; rl1 = nl && !deb_l; rr2 = rr1; rr1 = nr && !deb_r;
    if (nl) deb_l = !deb_l;
    if (nr) deb_r = !deb_r;
`ifndef LAP_RECALL_EN
    ar = 1'b0;
`endif
    if (clear) begin model_clear(time_in); return; end
    if (al) begin
      if (mode == 0) begin
        laps.push_back(time_in);
        if (laps.size() > N) void'(laps.pop_front());
        sc++; hold_v = time_in; mode = 1;
      end else mode = 0;
    end else if (ar) begin
      if (mode != 2 && laps.size() > 0) begin mode = 2; pos = 0; end
      else if (mode == 2) begin
        if (pos == laps.size() - 1) mode = 0;
        else pos++;
      end
    end
    exp_data = mode == 0 ? time_in : mode == 1 ? hold_v : laps[laps.size() - 1 - pos];
    exp_dp = mode == 2 ? 4'(1 << ((sc - 1 - pos) % N)) : 4'd0;
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  task automatic press(input bit l, input bit r);
    btn_lap = l; btn_recall = r;
    repeat (8) tick();
    btn_lap = 1'b0; btn_recall = 1'b0;
    repeat (8) tick();
  endtask
  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; time_in = 16'h1234; model_reset();
    repeat (3) tick();
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", data_out); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen: got %b want 0", frozen); end
    checks++; if (digit_point !== 4'd0) begin errors++; $display("FAIL reset_dp: got %b want 0000", digit_point); end
    checks++; if (lap_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", lap_count); end
    reset_n = 1'b1;
    tick();
    checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL live_follow: got %h want 1234", data_out); end
  endtask

  task automatic test_glitch();
    btn_lap = 1'b1; repeat (3) tick(); btn_lap = 1'b0;
    repeat (12) begin time_in = time_in + 16'd1; tick(); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL glitch_frozen: got %b want 0", frozen); end
    checks++; if (lap_count !== 3'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", lap_count); end
  endtask

  task automatic test_press();
    time_in = 16'h0105; btn_lap = 1'b1;
    repeat (7) tick();
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL press_early: got frozen %b want 0 at k+6", frozen); end
    tick();
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL press_hold: got frozen %b want 1 at k+7", frozen); end
    repeat (5) begin time_in = time_in + 16'd1; tick(); end
    checks++; if (data_out !== 16'h0105) begin errors++; $display("FAIL press_data: got %h want 0105", data_out); end
    checks++; if (lap_count !== 3'd1) begin errors++; $display("FAIL press_count: got %0d want 1", lap_count); end
    btn_lap = 1'b0; repeat (10) tick();
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL release_pulse: got frozen %b want 1", frozen); end
    press(1'b1, 1'b0);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL unhold: got frozen %b want 0", frozen); end
  endtask

  task automatic test_wrap();
    logic [15:0] wd [4];
    logic [3:0] wdp [4];
    wd = '{16'h0005, 16'h0004, 16'h0003, 16'h0002};
    wdp = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    do_clear();
    for (int i = 1; i <= 5; i++) begin time_in = 16'(i); press(1'b1, 1'b0); press(1'b1, 1'b0); end
    checks++; if (lap_count !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", lap_count); end
`ifdef LAP_RECALL_EN
    for (int i = 0; i < 4; i++) begin
      time_in = 16'($urandom);
      press(1'b0, 1'b1);
      checks++; if (data_out !== wd[i]) begin errors++; $display("FAIL recall_data%0d: got %h want %h", i, data_out, wd[i]); end
      checks++; if (digit_point !== wdp[i]) begin errors++; $display("FAIL recall_dp%0d: got %b want %b", i, digit_point, wdp[i]); end
    end
`endif
    press(1'b0, 1'b1);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL recall_exit: got frozen %b want 0", frozen); end
    checks++; if (digit_point !== 4'd0) begin errors++; $display("FAIL recall_exit_dp: got %b want 0000", digit_point); end
  endtask

  task automatic test_recall_empty();
    do_clear();
    time_in = 16'h4321;
    press(1'b0, 1'b1);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL empty_frozen: got %b want 0", frozen); end
    checks++; if (digit_point !== 4'd0) begin errors++; $display("FAIL empty_dp: got %b want 0000", digit_point); end
    checks++; if (data_out !== 16'h4321) begin errors++; $display("FAIL empty_data: got %h want 4321", data_out); end
  endtask

  task automatic test_simultaneous();
    time_in = 16'h0042;
    press(1'b1, 1'b1);
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL simul_frozen: got %b want 1", frozen); end
    checks++; if (lap_count !== 3'd1) begin errors++; $display("FAIL simul_count: got %0d want 1", lap_count); end
    checks++; if (digit_point !== 4'd0) begin errors++; $display("FAIL simul_dp: got %b want 0000", digit_point); end
    checks++; if (data_out !== 16'h0042) begin errors++; $display("FAIL simul_data: got %h want 0042", data_out); end
  endtask

  task automatic test_clear();
`ifdef LAP_RECALL_EN
    press(1'b0, 1'b1);
    checks++; if (digit_point !== 4'b0001) begin errors++; $display("FAIL clear_pre_dp: got %b want 0001", digit_point); end
`endif
    time_in = 16'hABCD; clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL clear_frozen: got %b want 0", frozen); end
    checks++; if (lap_count !== 3'd0) begin errors++; $display("FAIL clear_count: got %0d want 0", lap_count); end
    checks++; if (data_out !== 16'hABCD) begin errors++; $display("FAIL clear_data: got %h want abcd", data_out); end
    checks++; if (digit_point !== 4'd0) begin errors++; $display("FAIL clear_dp: got %b want 0000", digit_point); end
  endtask

  task automatic test_reset_mid();
    time_in = 16'h0777; btn_lap = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0; model_reset(); btn_lap = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL resetmid_frozen: got %b want 0", frozen); end
    checks++; if (lap_count !== 3'd0) begin errors++; $display("FAIL resetmid_count: got %0d want 0", lap_count); end
    checks++; if (data_out !== 16'h0777) begin errors++; $display("FAIL resetmid_data: got %h want 0777", data_out); end
  endtask

  task automatic test_random();
    int nl = 0, nr = 0;
    for (int c = 0; c < 3000 && errors < 20; c++) begin
      if (nl == 0) begin btn_lap = 1'($urandom_range(0, 1)); nl = $urandom_range(1, 12); end
      if (nr == 0) begin btn_recall = 1'($urandom_range(0, 1)); nr = $urandom_range(1, 12); end
      nl--; nr--;
      clear = $urandom_range(0, 150) == 0;
      if ($urandom_range(0, 3) == 0) time_in = 16'($urandom);
      tick();
      checks++; if (data_out !== exp_data) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, data_out, exp_data); end
      checks++; if (digit_point !== exp_dp) begin errors++; $display("FAIL rnd_dp c%0d: got %b want %b", c, digit_point, exp_dp); end
      checks++; if (lap_count !== 3'(laps.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, lap_count, laps.size()); end
      checks++; if (frozen !== (mode != 0)) begin errors++; $display("FAIL rnd_frozen c%0d: got %b want %b", c, frozen, mode != 0); end
    end
    clear = 1'b0; btn_lap = 1'b0; btn_recall = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_press();
    test_wrap();
    test_recall_empty();
    test_simultaneous();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
